// File: rtl/log_ctrl_pkg.sv
// Shared constants for the log capture controller: host opcodes, command and
// readback bit positions, arm modes and FSM state encoding.
package log_ctrl_pkg;

    // Host opcodes (cmd_q[31:24])
    localparam logic [7:0] OP_RST  = 8'h00;
    localparam logic [7:0] OP_READ = 8'h04;
    localparam logic [7:0] OP_ARM  = 8'h05;
    localparam logic [7:0] OP_THR  = 8'h06;

    // Command word fields
    localparam int unsigned CMD_EXEC   = 23;
    localparam int unsigned CMD_OP_LSB = 24;

    // Readback word fields
    localparam int unsigned GPI_FULL      = 31;
    localparam int unsigned GPI_EMPTY     = 30;
    localparam int unsigned GPI_OVER      = 29;
    localparam int unsigned GPI_STATE_LSB = 24;
    localparam int unsigned GPI_SEXT_MSB  = 23;

    typedef enum logic [1:0] {
        MODE_IMM = 2'd0,
        MODE_THR = 2'd1,
        MODE_EXT = 2'd2,
        MODE_RSV = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FULL    = 2'd3
    } state_e;

endpackage

// File: rtl/log_ram.sv
// Simple dual-port log RAM, DEPTH x NB_DATA: one write port, one registered
// synchronous read port (1-cycle latency). The array has no reset.
//   clk            : clock
//   we/waddr/wdata : write port
//   re/raddr       : read enable and address
//   rdata          : read data, valid the cycle after re
module log_ram
    import log_ctrl_pkg::*;
#(
    parameter int unsigned NB_DATA = 16,
    parameter int unsigned DEPTH   = 32768,
    parameter int unsigned NB_ADDR = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [NB_ADDR-1:0] waddr,
    input  logic [NB_DATA-1:0] wdata,
    input  logic               re,
    input  logic [NB_ADDR-1:0] raddr,
    output logic [NB_DATA-1:0] rdata
);

    logic [NB_DATA-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/log_capture_ctrl.sv
// Single-channel capture controller for the NB_CH-channel DSP sample bus.
// Stores the selected channel (with optional 2^n decimation) into log RAM after
// an immediate, threshold or external trigger; the host reads it back word by word.
//   clockdsp : clock            i_reset : synchronous active-high reset
//   gpo0     : host command     gpi0    : readback word
//   i_data   : channel samples  i_valid : sample strobe
//   i_trig   : external trigger o_busy  : high in ARMED or CAPTURE
module log_capture_ctrl
    import log_ctrl_pkg::*;
#(
    parameter int unsigned NB_DATA   = 16,
    parameter int unsigned NB_CH     = 4,
    parameter int unsigned DEPTH     = 32768,
    parameter int unsigned NB_ADDR   = $clog2(DEPTH),
    parameter int unsigned MAX_DECIM = 10
) (
    input  logic                     clockdsp,
    input  logic                     i_reset,
    input  logic [31:0]              gpo0,
    input  logic [NB_CH*NB_DATA-1:0] i_data,
    input  logic                     i_valid,
    input  logic                     i_trig,
    output logic [31:0]              gpi0,
    output logic                     o_busy
);

    localparam int unsigned NB_CHW = (NB_CH > 1) ? $clog2(NB_CH) : 1;
    localparam int unsigned NB_DEC = (MAX_DECIM > 0) ? MAX_DECIM : 1;
    localparam int unsigned NB_DL  = $clog2(MAX_DECIM + 1);

    state_e              state, state_nxt;
    logic [31:0]         cmd_q, cmd_prev;
    logic [7:0]          opcode;
    logic                cmd_new, do_srst, do_arm, do_thr, rd_strobe;
    logic [NB_DL-1:0]    decim_q;
    logic [NB_CHW-1:0]   ch_q;
    mode_e               mode_q;
    logic [NB_DATA-1:0]  thr_q, sample, sample_mag, rd_data;
    logic [NB_DEC-1:0]   dec_cnt, dec_mask;
    logic [NB_ADDR:0]    wr_cnt;        // one extra bit so FULL is distinct from empty
    logic [NB_ADDR-1:0]  rd_ptr;
    logic                rd_pend, rd_over_q;
    logic                trig_hit, cap_write, last_addr;
    logic [31:0]         rd_word;

    // Magnitude with the most negative code saturating to the largest positive
    function automatic logic [NB_DATA-1:0] mag(input logic [NB_DATA-1:0] x);
        if (!x[NB_DATA-1]) return x;
        if (x == {1'b1, {(NB_DATA-1){1'b0}}}) return {1'b0, {(NB_DATA-1){1'b1}}};
        return ~x + NB_DATA'(1);
    endfunction

    // Command capture; a command is new when cmd_q differs from its previous value
    always_ff @(posedge clockdsp) begin
        if (i_reset) begin
            cmd_q    <= '0;
            cmd_prev <= '0;
        end else begin
            cmd_q    <= gpo0;
            cmd_prev <= cmd_q;
        end
    end

    // Command decode
    always_comb begin
        opcode    = cmd_q[CMD_OP_LSB +: 8];
        cmd_new   = (cmd_q != cmd_prev) && cmd_q[CMD_EXEC];
        do_srst   = cmd_new && (opcode == OP_RST) && !cmd_q[0];
        do_arm    = cmd_new && (opcode == OP_ARM);
        do_thr    = cmd_new && (opcode == OP_THR);
        rd_strobe = cmd_new && (opcode == OP_READ) && cmd_q[0] && !cmd_prev[0]
                    && ((state == ST_IDLE) || (state == ST_FULL));
    end

    // Channel select, magnitude and decimation mask
    always_comb begin
        sample = '0;
        for (int unsigned k = 0; k < NB_CH; k++) begin
            if (ch_q == NB_CHW'(k)) sample = i_data[k*NB_DATA +: NB_DATA];
        end
        sample_mag = mag(sample);
        dec_mask   = ~({NB_DEC{1'b1}} << decim_q);
    end

    // FSM state register
    always_ff @(posedge clockdsp) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // FSM next state; soft reset and re-arm take priority over capture
    always_comb begin
        state_nxt = state;
        if (do_srst) begin
            state_nxt = ST_IDLE;
        end else if (do_arm) begin
            state_nxt = ST_ARMED;
        end else begin
            case (state)
                ST_ARMED:   if (cap_write) state_nxt = last_addr ? ST_FULL : ST_CAPTURE;
                ST_CAPTURE: if (cap_write && last_addr) state_nxt = ST_FULL;
                default:    ;
            endcase
        end
    end

    // FSM outputs: trigger qualification and capture write strobe
    always_comb begin
        case (mode_q)
            MODE_THR: trig_hit = (sample_mag >= thr_q);
            MODE_EXT: trig_hit = i_trig;
            default:  trig_hit = 1'b1;
        endcase
        cap_write = 1'b0;
        if (i_valid && !do_srst && !do_arm) begin
            case (state)
                ST_ARMED:   cap_write = trig_hit;
                ST_CAPTURE: cap_write = (dec_cnt == '0);
                default:    ;
            endcase
        end
        last_addr = (wr_cnt[NB_ADDR-1:0] == NB_ADDR'(DEPTH - 1));
    end

    // Readback word assembly
    always_comb begin
        rd_word                     = '0;
        rd_word[GPI_SEXT_MSB:0]     = {{(24-NB_DATA){rd_data[NB_DATA-1]}}, rd_data};
        rd_word[GPI_STATE_LSB +: 2] = state;
        rd_word[GPI_OVER]           = rd_over_q;
        rd_word[GPI_EMPTY]          = (wr_cnt == '0);
        rd_word[GPI_FULL]           = (state == ST_FULL);
    end

    // Configuration, pointers and output registers
    always_ff @(posedge clockdsp) begin
        if (i_reset || do_srst) begin
            decim_q   <= '0;
            ch_q      <= '0;
            mode_q    <= MODE_IMM;
            thr_q     <= '0;
            dec_cnt   <= '0;
            wr_cnt    <= '0;
            rd_ptr    <= '0;
            rd_pend   <= 1'b0;
            rd_over_q <= 1'b0;
            gpi0      <= '0;
            o_busy    <= 1'b0;
        end else begin
            o_busy <= (state_nxt == ST_ARMED) || (state_nxt == ST_CAPTURE);
            if (cap_write) wr_cnt <= wr_cnt + (NB_ADDR+1)'(1);
            // Decimation phase counts every sample from the trigger onward
            if (cap_write || (i_valid && (state == ST_CAPTURE)))
                dec_cnt <= (dec_cnt + NB_DEC'(1)) & dec_mask;
            if (do_thr) thr_q <= cmd_q[NB_DATA-1:0];
            if (do_arm) begin
                decim_q <= (32'(cmd_q[7:4]) > MAX_DECIM) ? NB_DL'(MAX_DECIM) : NB_DL'(cmd_q[7:4]);
                ch_q    <= (32'(cmd_q[11:8]) >= NB_CH) ? NB_CHW'(NB_CH - 1) : NB_CHW'(cmd_q[11:8]);
                mode_q  <= mode_e'(cmd_q[13:12]);
                dec_cnt <= '0;
                wr_cnt  <= '0;
                rd_ptr  <= '0;
            end
            rd_pend <= rd_strobe;
            if (rd_strobe) begin
                rd_ptr    <= rd_ptr + NB_ADDR'(1);
                rd_over_q <= ({1'b0, rd_ptr} >= wr_cnt);
            end
            if (rd_pend) gpi0 <= rd_word;
        end
    end

    log_ram #(
        .NB_DATA (NB_DATA),
        .DEPTH   (DEPTH),
        .NB_ADDR (NB_ADDR)
    ) u_ram (
        .clk   (clockdsp),
        .we    (cap_write),
        .waddr (wr_cnt[NB_ADDR-1:0]),
        .wdata (sample),
        .re    (rd_strobe),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_log_capture_ctrl.sv
// Directed bench for log_capture_ctrl with a shallow RAM (DEPTH=64).
module tb_log_capture_ctrl;

    localparam int unsigned NB_DATA = 16;
    localparam int unsigned NB_CH   = 4;
    localparam int unsigned DEPTH   = 64;

    logic                     clockdsp = 1'b0;
    logic                     i_reset  = 1'b1;
    logic [31:0]              gpo0     = '0;
    logic [NB_CH*NB_DATA-1:0] i_data   = '0;
    logic                     i_valid  = 1'b0;
    logic                     i_trig   = 1'b0;
    logic [31:0]              gpi0;
    logic                     o_busy;

    int          errs   = 0;
    int          checks = 0;
    logic [31:0] rv;

    log_capture_ctrl #(
        .NB_DATA (NB_DATA),
        .NB_CH   (NB_CH),
        .DEPTH   (DEPTH)
    ) dut (
        .clockdsp (clockdsp),
        .i_reset  (i_reset),
        .gpo0     (gpo0),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .i_trig   (i_trig),
        .gpi0     (gpi0),
        .o_busy   (o_busy)
    );

    always #5 clockdsp = ~clockdsp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clockdsp);
        #1;
    endtask

    task automatic cmd(input logic [31:0] w);
        gpo0 = w;
        tick(3);
    endtask

    task automatic smp(input logic [15:0] v, input int ch, input logic trig);
        for (int k = 0; k < NB_CH; k++)
            i_data[k*NB_DATA +: NB_DATA] = (k == ch) ? v : 16'h7EEE;
        i_valid = 1'b1;
        i_trig  = trig;
        tick(1);
        i_valid = 1'b0;
        i_trig  = 1'b0;
        tick(3);
    endtask

    task automatic fill(input int n, input int base, input int ch);
        for (int i = 0; i < n; i++) smp(16'(base + i), ch, 1'b0);
    endtask

    task automatic rd(output logic [31:0] v);
        cmd(32'h0480_0000);
        cmd(32'h0480_0001);
        v = gpi0;
    endtask

    initial begin
        // Reset
        tick(3);
        i_reset = 1'b0;
        tick(1);
        check("rst_gpi0", gpi0, 32'h0);
        check("rst_busy", 32'(o_busy), 32'd0);

        // Soft reset commands, then a read in IDLE: empty + overread, state 0
        cmd(32'h0080_0000);
        cmd(32'h0080_0001);
        rd(rv);
        check("idle_flags", 32'(rv[31:24]), 32'h60);
        check("idle_busy", 32'(o_busy), 32'd0);

        // Mode 0, channel 2, no decimation: ramp fills RAM
        cmd(32'h0580_0200);
        check("arm_busy", 32'(o_busy), 32'd1);
        fill(DEPTH - 1, 0, 2);
        check("busy_before_full", 32'(o_busy), 32'd1);
        smp(16'(DEPTH - 1), 2, 1'b0);
        check("busy_after_full", 32'(o_busy), 32'd0);
        fill(4, DEPTH, 2);
        // Exact read latency on the first word
        cmd(32'h0480_0000);
        gpo0 = 32'h0480_0001;
        tick(2);
        check("lat_early", 32'(gpi0[31:24]), 32'h60);
        tick(1);
        check("lat_word0", gpi0, 32'h8300_0000);
        tick(1);
        for (int k = 1; k < DEPTH; k++) begin
            rd(rv);
            check($sformatf("ramp%0d", k), rv, 32'h8300_0000 | 32'(k));
        end
        rd(rv);
        check("rd_wrap", rv, 32'h8300_0000);

        // Decimation by 8 on channel 0; a read mid-capture is ignored
        cmd(32'h0580_0030);
        fill(80, 0, 0);
        check("dec_busy", 32'(o_busy), 32'd1);
        rd(rv);
        check("rd_in_capture", rv, 32'h8300_0000);
        fill(DEPTH * 8 - 80, 80, 0);
        check("dec_full", 32'(o_busy), 32'd0);
        for (int k = 0; k < 10; k++) begin
            rd(rv);
            check($sformatf("dec%0d", k), rv, 32'h8300_0000 | 32'(8 * k));
        end

        // Threshold: saturated magnitude of 0x8000 must not reach 0x8000
        cmd(32'h0680_8000);
        cmd(32'h0580_1000);
        smp(16'h8000, 0, 1'b0);
        check("thr_sat_armed", 32'(o_busy), 32'd1);
        cmd(32'h0680_7FFF);
        smp(16'h1234, 0, 1'b0);
        smp(16'h8001, 0, 1'b0);
        fill(DEPTH - 1, 0, 0);
        check("thr_sat_full", 32'(o_busy), 32'd0);
        rd(rv);
        check("thr_sat_w0", rv, 32'h83FF_8001);
        rd(rv);
        check("thr_sat_w1", rv, 32'h8300_0000);

        // Threshold 0x100: 0x50 below, -0x120 triggers
        cmd(32'h0680_0100);
        cmd(32'h0580_1000);
        smp(16'h0050, 0, 1'b0);
        smp(16'hFEE0, 0, 1'b0);
        smp(16'h0010, 0, 1'b0);
        fill(DEPTH - 2, 16'h20, 0);
        rd(rv);
        check("thr_w0", rv, 32'h83FF_FEE0);
        rd(rv);
        check("thr_w1", rv, 32'h8300_0010);

        // External trigger
        cmd(32'h0580_2000);
        fill(100, 16'h0500, 0);
        check("ext_wait_busy", 32'(o_busy), 32'd1);
        smp(16'h0ABC, 0, 1'b1);
        fill(DEPTH - 1, 16'h0100, 0);
        check("ext_full", 32'(o_busy), 32'd0);
        rd(rv);
        check("ext_w0", rv, 32'h8300_0ABC);
        rd(rv);
        check("ext_w1", rv, 32'h8300_0100);

        // Channel clamp (7 -> 3), ignored read, re-arm mid-capture
        cmd(32'h0580_0700);
        fill(10, 16'h0300, 3);
        rd(rv);
        check("cap_rd_ignored", rv, 32'h8300_0100);
        cmd(32'h0580_0700);
        check("rearm_busy", 32'(o_busy), 32'd1);
        fill(DEPTH, 16'h0400, 3);
        check("rearm_full", 32'(o_busy), 32'd0);
        rd(rv);
        check("rearm_w0", rv, 32'h8300_0400);
        rd(rv);
        check("rearm_w1", rv, 32'h8300_0401);

        // Soft reset from FULL
        cmd(32'h0080_0000);
        check("srst_busy", 32'(o_busy), 32'd0);
        rd(rv);
        check("srst_flags", 32'(rv[31:24]), 32'h60);

        // i_reset during a read clears gpi0 and cancels the pending read
        cmd(32'h0480_0000);
        gpo0 = 32'h0480_0001;
        tick(1);
        i_reset = 1'b1;
        gpo0    = 32'h0;
        tick(1);
        check("rst_mid_read", gpi0, 32'h0);
        tick(2);
        check("rst_mid_read_hold", gpi0, 32'h0);
        i_reset = 1'b0;
        tick(3);
        check("rst_end_busy", 32'(o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
